lvds_tx_link_ctrl: RTL and testbench

//  Link sequencer in front of the 8:1 LVDS OSERDES transmit datapath, running on its divided clock (CLK_DIV).
//  - Brings the link up by sending a training pattern, then a sync word, then user data.
//  - Accepts user beats over a valid/ready handshake and inserts periodic re-sync words.
//  - Supports retraining on request.
//  - Drives TX_DATA/TX_DVLD of the serializer interface; lane i occupies TX_DATA[i*8+7:i*8], MSB shifted first.

---
 rtl/lvds_tx_pkg.sv | 26 ++
 rtl/lvds_tx_prbs7.sv | 38 +++
 rtl/lvds_tx_link_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_lvds_tx_link_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_tx_pkg.sv
// Shared definitions for the LVDS transmit link sequencer: one-hot FSM state
// encoding, default per-lane pattern bytes and a constant-sizing helper.
package lvds_tx_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_TRAIN = 4'b0010,
    ST_SYNC  = 4'b0100,
    ST_DATA  = 4'b1000
  } state_e;

  localparam logic [7:0] C_TRAIN_PAT = 8'hF0;
  localparam logic [7:0] C_SYNC_WORD = 8'hA5;
  localparam logic [7:0] C_IDLE_PAT  = 8'h3C;

  // Largest of three lengths, used to size the shared beat counters.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/lvds_tx_prbs7.sv
// Per-lane PRBS7 generator (x^7 + x^6 + 1). Produces the next 8 sequence bits
// for one serializer beat, first-generated bit in the MSB (shifted out first).
// Only instantiated when LVDS_TX_PRBS_EN is defined.
module lvds_tx_prbs7 #(
  parameter logic [6:0] SEED = 7'h7F
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       adv_i,
  output logic [7:0] byte_o
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_next;
  logic       fb;

  // Unroll eight LFSR steps to form one beat's byte and the advanced state.
  always_comb begin
    lfsr_next = lfsr_q;
    byte_o    = 8'h00;
    fb        = 1'b0;
    for (int k = 0; k < 8; k++) begin
      fb            = lfsr_next[6] ^ lfsr_next[5];
      byte_o[7 - k] = fb;
      lfsr_next     = {lfsr_next[5:0], fb};
    end
  end

  // Hold the state unless a PRBS beat is emitted, so sync slots freeze it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= SEED;
    end else if (adv_i) begin
      lfsr_q <= lfsr_next;
    end
  end

endmodule

// File: rtl/lvds_tx_link_ctrl.sv
// Link sequencer in front of an 8:1 LVDS serializer, clocked on the divided
// clock. Brings the link up with TRAIN then SYNC beats, then forwards user
// beats over valid/ready, inserting a sync word every SYNC_PERIOD data beats.
// Optional feature macro: LVDS_TX_PRBS_EN adds prbs_mode_i and per-lane PRBS7.
module lvds_tx_link_ctrl
  import lvds_tx_pkg::*;
#(
  parameter int unsigned DB_W        = 16,
  parameter int unsigned TRAIN_LEN   = 256,
  parameter int unsigned SYNC_LEN    = 4,
  parameter int unsigned SYNC_PERIOD = 1024,
  parameter logic [7:0]  TRAIN_PAT   = C_TRAIN_PAT,
  parameter logic [7:0]  SYNC_WORD   = C_SYNC_WORD,
  parameter logic [7:0]  IDLE_PAT    = C_IDLE_PAT
) (
  input  logic              clk_div_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              retrain_i,
  input  logic              usr_vld_i,
  input  logic [DB_W*8-1:0] usr_data_i,
`ifdef LVDS_TX_PRBS_EN
  input  logic              prbs_mode_i,
`endif
  output logic              usr_rdy_o,
  output logic              tx_dvld_o,
  output logic [DB_W*8-1:0] tx_data_o,
  output logic              link_up_o,
  output logic [7:0]        train_cnt_o
);

  localparam int unsigned DW     = DB_W * 8;
  localparam int unsigned CntMax = max3(TRAIN_LEN, SYNC_LEN, SYNC_PERIOD);
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [CntW-1:0] TrainLast = CntW'(TRAIN_LEN);
  localparam logic [CntW-1:0] SyncLast  = CntW'(SYNC_LEN);
  localparam logic [CntW-1:0] SlotBeat  = (SYNC_PERIOD == 0) ? '0 : CntW'(SYNC_PERIOD - 1);
  localparam logic            SlotEn    = (SYNC_PERIOD != 0);

  localparam logic [DW-1:0] TrainWord = {DB_W{TRAIN_PAT}};
  localparam logic [DW-1:0] SyncWord  = {DB_W{SYNC_WORD}};
  localparam logic [DW-1:0] IdleWord  = {DB_W{IDLE_PAT}};

  state_e          state_q;
  logic [CntW-1:0] cnt_q;      // beats emitted in the current TRAIN/SYNC phase
  logic [CntW-1:0] beat_q;     // DATA beats since entry or last inserted sync
  logic [7:0]      train_cnt_q;
  logic [DW-1:0]   tx_data_q;
  logic            tx_dvld_q;
  logic            link_up_q;

  logic            sync_slot;
  logic            xfer;
  logic            prbs_mode;
  logic [DW-1:0]   prbs_word;

  assign sync_slot = SlotEn && (state_q == ST_DATA) && (beat_q == SlotBeat);

  // Ready never depends on usr_vld_i; the retrain and sync-slot cycles refuse data.
  assign usr_rdy_o = (state_q == ST_DATA) && enable_i && !retrain_i && !sync_slot && !prbs_mode;
  assign xfer      = usr_vld_i && usr_rdy_o;

`ifdef LVDS_TX_PRBS_EN
  logic prbs_adv;

  assign prbs_mode = prbs_mode_i;
  assign prbs_adv  = (state_q == ST_DATA) && enable_i && !retrain_i && !sync_slot && prbs_mode;

  for (genvar i = 0; i < DB_W; i++) begin : g_prbs
    // 7'h7F + 1 wraps to zero, which would lock the LFSR; that lane uses 7'h01.
    localparam logic [6:0] RawSeed = 7'(32'h7F + i);
    localparam logic [6:0] Seed    = (RawSeed == 7'h00) ? 7'h01 : RawSeed;

    lvds_tx_prbs7 #(
      .SEED(Seed)
    ) u_prbs (
      .clk_i (clk_div_i),
      .rst_i (rst_i),
      .adv_i (prbs_adv),
      .byte_o(prbs_word[i*8 +: 8])
    );
  end
`else
  assign prbs_mode = 1'b0;
  assign prbs_word = '0;
`endif

  // Sequencer FSM with registered serializer outputs; ENABLE low overrides all.
  always_ff @(posedge clk_div_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      beat_q      <= '0;
      train_cnt_q <= 8'h00;
      tx_data_q   <= '0;
      tx_dvld_q   <= 1'b0;
      link_up_q   <= 1'b0;
    end else if (!enable_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      beat_q    <= '0;
      tx_data_q <= '0;
      tx_dvld_q <= 1'b0;
      link_up_q <= 1'b0;
    end else begin
      tx_dvld_q <= 1'b0;
      link_up_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          state_q   <= ST_TRAIN;
          cnt_q     <= CntOne;
          tx_data_q <= TrainWord;
        end
        ST_TRAIN: begin
          if (cnt_q == TrainLast) begin
            state_q   <= ST_SYNC;
            cnt_q     <= CntOne;
            tx_data_q <= SyncWord;
            if (train_cnt_q != 8'hFF) begin
              train_cnt_q <= train_cnt_q + 8'd1;
            end
          end else begin
            cnt_q     <= cnt_q + CntOne;
            tx_data_q <= TrainWord;
          end
        end
        ST_SYNC: begin
          if (cnt_q == SyncLast) begin
            state_q   <= ST_DATA;
            cnt_q     <= '0;
            beat_q    <= '0;
            tx_data_q <= IdleWord;
            link_up_q <= 1'b1;
          end else begin
            cnt_q     <= cnt_q + CntOne;
            tx_data_q <= SyncWord;
          end
        end
        ST_DATA: begin
          if (retrain_i) begin
            state_q   <= ST_TRAIN;
            cnt_q     <= CntOne;
            beat_q    <= '0;
            tx_data_q <= TrainWord;
          end else begin
            link_up_q <= 1'b1;
            if (sync_slot) begin
              beat_q    <= '0;
              tx_data_q <= SyncWord;
            end else begin
              beat_q <= beat_q + CntOne;
              if (prbs_mode) begin
                tx_data_q <= prbs_word;
                tx_dvld_q <= 1'b1;
              end else if (xfer) begin
                tx_data_q <= usr_data_i;
                tx_dvld_q <= 1'b1;
              end else begin
                tx_data_q <= IdleWord;
              end
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          beat_q    <= '0;
          tx_data_q <= '0;
        end
      endcase
    end
  end

  assign tx_data_o   = tx_data_q;
  assign tx_dvld_o   = tx_dvld_q;
  assign link_up_o   = link_up_q;
  assign train_cnt_o = train_cnt_q;

endmodule

// File: tb/tb_lvds_tx_link_ctrl.sv
// Self-checking bench for lvds_tx_link_ctrl with DB_W=2, TRAIN_LEN=8,
// SYNC_LEN=2, SYNC_PERIOD=6. The model tracks the index k of the beat emitted
// since training last (re)started and derives every output from it.
module tb_lvds_tx_link_ctrl;

  localparam int TrainLen   = 8;
  localparam int SyncLen    = 2;
  localparam int SyncPeriod = 6;
  localparam int DataK      = TrainLen + SyncLen;  // beat index of DATA entry

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        rt  = 1'b0;
  logic        vld = 1'b0;
  logic [15:0] din = 16'h0000;
  logic        prbs_mode = 1'b0;
  logic        rdy;
  logic        dvld;
  logic [15:0] dout;
  logic        link;
  logic [7:0]  tcnt;

  always #5 clk = ~clk;

  lvds_tx_link_ctrl #(
    .DB_W       (2),
    .TRAIN_LEN  (TrainLen),
    .SYNC_LEN   (SyncLen),
    .SYNC_PERIOD(SyncPeriod)
  ) dut (
    .clk_div_i  (clk),
    .rst_i      (rst),
    .enable_i   (en),
    .retrain_i  (rt),
    .usr_vld_i  (vld),
    .usr_data_i (din),
`ifdef LVDS_TX_PRBS_EN
    .prbs_mode_i(prbs_mode),
`endif
    .usr_rdy_o  (rdy),
    .tx_dvld_o  (dvld),
    .tx_data_o  (dout),
    .link_up_o  (link),
    .train_cnt_o(tcnt)
  );

  int n_checks = 0;
  int n_errors = 0;
  int k  = -1;     // -1: idle
  int tc = 0;      // completed training phases
  bit last_xfer;
  bit hist[$];     // last 7 PRBS bits of lane 0, oldest first

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic void prbs_reset();
    hist.delete();
    for (int n = 0; n < 7; n++) hist.push_back(1'b1);
  endfunction

  // b[n] = b[n-7] ^ b[n-6]
  function automatic logic [7:0] prbs_byte();
    logic [7:0] b;
    bit nb;
    b = 8'h00;
    for (int n = 0; n < 8; n++) begin
      nb = hist[0] ^ hist[1];
      hist.push_back(nb);
      void'(hist.pop_front());
      b[7-n] = nb;
    end
    return b;
  endfunction

  // Inputs are set ~1 time unit after an edge; checks ready, then the next edge.
  task automatic step();
    bit          in_data;
    bit          slot;
    bit          exp_rdy;
    bit          prbs_beat;
    logic [15:0] exp_d;
    logic        exp_v;
    logic [7:0]  lane0;
    #1;
    in_data = (k >= DataK);
    slot    = in_data && (((k - DataK) % SyncPeriod) == SyncPeriod - 1);
    exp_rdy = in_data && en && !rt && !slot && !prbs_mode;
    check("usr_rdy", 32'(rdy), 32'(exp_rdy));
    last_xfer = exp_rdy && vld;
    exp_d = 16'h0000;
    exp_v = 1'b0;
    lane0 = 8'h00;
    prbs_beat = 1'b0;
    if (!en) k = -1;
    else if (k < 0 || (in_data && rt)) k = 0;
    else begin
      k++;
      if (k == TrainLen) tc = (tc < 255) ? tc + 1 : 255;
    end
    if (k >= 0) begin
      if (k < TrainLen) exp_d = 16'hF0F0;
      else if (k < DataK) exp_d = 16'hA5A5;
      else if (k == DataK) exp_d = 16'h3C3C;
      else if (slot) exp_d = 16'hA5A5;
      else if (prbs_mode) begin
        prbs_beat = 1'b1;
        exp_v = 1'b1;
        lane0 = prbs_byte();
      end else if (vld) begin
        exp_d = din;
        exp_v = 1'b1;
      end else exp_d = 16'h3C3C;
    end
    @(posedge clk);
    #1;
    if (prbs_beat) check("tx_data_lane0", 32'(dout[7:0]), 32'(lane0));
    else check("tx_data", 32'(dout), 32'(exp_d));
    check("tx_dvld", 32'(dvld), 32'(exp_v));
    check("link_up", 32'(link), 32'(k >= DataK));
    check("train_cnt", 32'(tcnt), 32'(tc));
  endtask

  initial begin
    prbs_reset();
    #22;
    check("rst_tx_data", 32'(dout), 32'h0);
    check("rst_tx_dvld", 32'(dvld), 32'h0);
    check("rst_link_up", 32'(link), 32'h0);
    check("rst_train_cnt", 32'(tcnt), 32'h0);
    check("rst_usr_rdy", 32'(rdy), 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Bring-up with no user data: 8 train, 2 sync, idle pattern.
    en = 1'b1;
    repeat (14) step();

    // Streaming counter data across several sync slots.
    vld = 1'b1;
    din = 16'h0001;
    repeat (30) begin
      step();
      if (last_xfer) din = din + 16'h0001;
    end

    // Transfer 16'h1234, then retrain.
    din = 16'h1234;
    for (int i = 0; i < 8; i++) begin
      step();
      if (last_xfer) break;
    end
    vld = 1'b0;
    rt  = 1'b1;
    step();
    rt = 1'b0;
    repeat (12) step();

    // Drop ENABLE after the fourth training beat, then re-enable.
    rt = 1'b1;
    step();
    rt = 1'b0;
    for (int i = 0; i < 20 && k != 3; i++) step();
    en = 1'b0;
    step();
    en = 1'b1;
    repeat (14) step();

    // Randomized traffic with occasional enable drops and retrains.
    for (int i = 0; i < 1500; i++) begin
      en  = ($urandom_range(0, 99) != 0);
      rt  = ($urandom_range(0, 29) == 0);
      vld = ($urandom_range(0, 3) != 0);
      din = 16'($urandom);
      step();
    end

    en  = 1'b1;
    rt  = 1'b0;
    vld = 1'b0;
    for (int i = 0; i < 30 && k < DataK + 3; i++) step();

`ifdef LVDS_TX_PRBS_EN
    prbs_mode = 1'b1;
    vld = 1'b1;
    repeat (100) step();
    prbs_mode = 1'b0;
    vld = 1'b0;
    repeat (4) step();
`endif

    // Asynchronous reset between edges while in DATA.
    #3;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    check("arst_tx_data", 32'(dout), 32'h0);
    check("arst_tx_dvld", 32'(dvld), 32'h0);
    check("arst_link_up", 32'(link), 32'h0);
    check("arst_train_cnt", 32'(tcnt), 32'h0);
    check("arst_usr_rdy", 32'(rdy), 32'h0);
    #2;
    rst = 1'b0;
    k  = -1;
    tc = 0;
    prbs_reset();
    @(posedge clk);
    #1;
    en = 1'b1;
    repeat (12) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
